key_pad_emu: RTL and testbench

KEY_PAD_EMU -- requirements
Module: key_pad_emu

---
 rtl/key_pad_emu.sv | 131 +++++++++++++
 tb/tb_key_pad_emu.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/key_pad_emu.sv
// Keypad contact emulator: presses one key on a scanned 4x4 matrix.
// The contact bounces in, holds steadily, then bounces out.
module key_pad_emu #(
    parameter int HOLD_CYC   = 1000000,
    parameter int BOUNCE_CYC = 5000,
    parameter int BOUNCE_N   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col,
    output logic [3:0] row,
    input  logic       press_valid,
    input  logic [3:0] press_code,
    output logic       press_ready,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE,
        BNC_IN,
        HOLD,
        BNC_OUT
    } state_t;

    localparam logic [23:0] HOLD_LAST = 24'(HOLD_CYC - 1);
    localparam logic [23:0] BNC_LAST  = 24'(BOUNCE_CYC - 1);
    localparam logic [7:0]  TOG_LAST  = 8'(BOUNCE_N - 1);

    state_t      state;
    logic        contact;
    logic [3:0]  code_q;
    logic [23:0] phase_cnt;
    logic [7:0]  toggle_cnt;
    logic [3:0]  row_next;

    assign press_ready = (state == IDLE);
    assign busy        = (state != IDLE);

    // Only the pressed key's column is looked at; its row is pulled low.
    always_comb begin
        row_next = 4'b1111;
        if (contact && !col[code_q[1:0]]) begin
            row_next[code_q[3:2]] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            contact    <= 1'b0;
            row        <= 4'b1111;
            done       <= 1'b0;
            code_q     <= 4'h0;
            phase_cnt  <= 24'd0;
            toggle_cnt <= 8'd0;
        end else begin
            done <= 1'b0;
            row  <= row_next;
            case (state)
                IDLE: begin
                    if (press_valid) begin
                        code_q     <= press_code;
                        phase_cnt  <= 24'd0;
                        toggle_cnt <= 8'd0;
                        if (BOUNCE_N == 0) begin
                            state   <= HOLD;
                            contact <= 1'b1;
                        end else begin
                            state   <= BNC_IN;
                            contact <= 1'b0;
                        end
                    end
                end
                BNC_IN: begin
                    if (phase_cnt == BNC_LAST) begin
                        phase_cnt <= 24'd0;
                        // The last bounce phase ends by settling closed.
                        if (toggle_cnt == TOG_LAST) begin
                            state      <= HOLD;
                            contact    <= 1'b1;
                            toggle_cnt <= 8'd0;
                        end else begin
                            contact    <= ~contact;
                            toggle_cnt <= toggle_cnt + 8'd1;
                        end
                    end else begin
                        phase_cnt <= phase_cnt + 24'd1;
                    end
                end
                HOLD: begin
                    if (phase_cnt == HOLD_LAST) begin
                        phase_cnt  <= 24'd0;
                        toggle_cnt <= 8'd0;
                        if (BOUNCE_N == 0) begin
                            state   <= IDLE;
                            contact <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            state   <= BNC_OUT;
                            contact <= 1'b1;
                        end
                    end else begin
                        phase_cnt <= phase_cnt + 24'd1;
                    end
                end
                BNC_OUT: begin
                    if (phase_cnt == BNC_LAST) begin
                        phase_cnt <= 24'd0;
                        if (toggle_cnt == TOG_LAST) begin
                            state      <= IDLE;
                            contact    <= 1'b0;
                            toggle_cnt <= 8'd0;
                            done       <= 1'b1;
                        end else begin
                            contact    <= ~contact;
                            toggle_cnt <= toggle_cnt + 8'd1;
                        end
                    end else begin
                        phase_cnt <= phase_cnt + 24'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    contact <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_pad_emu.sv
// Scoreboard bench for key_pad_emu: a bouncing instance and a zero-bounce instance
// are checked every cycle against a waveform-level model of the key contact.
module tb_key_pad_emu;

    localparam int HOLD = 20;
    localparam int BC   = 3;
    localparam int BN   = 4;

    localparam int MODE_CONST  = 0;
    localparam int MODE_ROTATE = 1;
    localparam int MODE_RAND   = 2;

    typedef struct {
        logic [3:0] row;
        logic       done;
        logic       ready;
        logic       busy;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] col         [2];
    logic [3:0] row         [2];
    logic       press_valid [2];
    logic [3:0] press_code  [2];
    logic       press_ready [2];
    logic       busy        [2];
    logic       done        [2];

    exp_t q0[$];
    exp_t q1[$];

    int n_checks = 0;
    int n_fail   = 0;

    bit         m_busy [2];
    int         m_k    [2];
    logic [3:0] m_code [2];

    key_pad_emu #(.HOLD_CYC(HOLD), .BOUNCE_CYC(BC), .BOUNCE_N(BN)) u_dut (
        .clk(clk), .rst(rst), .col(col[0]), .row(row[0]),
        .press_valid(press_valid[0]), .press_code(press_code[0]),
        .press_ready(press_ready[0]), .busy(busy[0]), .done(done[0])
    );

    key_pad_emu #(.HOLD_CYC(HOLD), .BOUNCE_CYC(BC), .BOUNCE_N(0)) u_zero (
        .clk(clk), .rst(rst), .col(col[1]), .row(row[1]),
        .press_valid(press_valid[1]), .press_code(press_code[1]),
        .press_ready(press_ready[1]), .busy(busy[1]), .done(done[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Contact state during the k-th cycle after accept, read off the press waveform:
    // bn bounce phases starting open, a steady hold, then bn phases starting closed.
    function automatic logic exp_contact(input int k, input int bn);
        int in_len;
        in_len = bn * BC;
        if (k < in_len) return ((k / BC) % 2) == 1;
        if (k < in_len + HOLD) return 1'b1;
        return (((k - in_len - HOLD) / BC) % 2) == 0;
    endfunction

    task automatic checkOutput(input string name, input logic [3:0] actual,
                               input logic [3:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s at t=%0t: got %b, expected %b", name, $time, actual, expected);
        end
    endtask

    // Reference model: predicts what each instance shows after every rising edge.
    initial begin
        exp_t e;
        int   bn;
        logic c;
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++) begin
                bn = (i == 0) ? BN : 0;
                if (rst) begin
                    m_busy[i] = 1'b0;
                    m_k[i]    = 0;
                    m_code[i] = 4'h0;
                    e = '{row: 4'hF, done: 1'b0, ready: 1'b1, busy: 1'b0};
                end else begin
                    c = m_busy[i] && exp_contact(m_k[i], bn);
                    e.row = 4'hF;
                    if (c && !col[i][m_code[i][1:0]]) e.row[m_code[i][3:2]] = 1'b0;
                    e.done = 1'b0;
                    if (m_busy[i]) begin
                        m_k[i]++;
                        if (m_k[i] == 2 * bn * BC + HOLD) begin
                            m_busy[i] = 1'b0;
                            e.done    = 1'b1;
                        end
                    end else if (press_valid[i]) begin
                        m_busy[i] = 1'b1;
                        m_k[i]    = 0;
                        m_code[i] = press_code[i];
                    end
                    e.ready = !m_busy[i];
                    e.busy  = m_busy[i];
                end
                if (i == 0) q0.push_back(e);
                else q1.push_back(e);
            end
        end
    end

    // Monitor: pops one prediction per instance per cycle and compares mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                checkOutput("row", row[0], e.row);
                checkOutput("done", {3'b0, done[0]}, {3'b0, e.done});
                checkOutput("press_ready", {3'b0, press_ready[0]}, {3'b0, e.ready});
                checkOutput("busy", {3'b0, busy[0]}, {3'b0, e.busy});
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                checkOutput("zero_row", row[1], e.row);
                checkOutput("zero_done", {3'b0, done[1]}, {3'b0, e.done});
                checkOutput("zero_press_ready", {3'b0, press_ready[1]}, {3'b0, e.ready});
                checkOutput("zero_busy", {3'b0, busy[1]}, {3'b0, e.busy});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int inst, input logic [3:0] code, input logic [3:0] c);
        col[inst]         = c;
        press_valid[inst] = 1'b1;
        press_code[inst]  = code;
        step();
        press_valid[inst] = 1'b0;
    endtask

    task automatic runCycles(input int inst, input int n, input int mode, input logic [3:0] c);
        for (int k = 0; k < n; k++) begin
            case (mode)
                MODE_CONST:  col[inst] = c;
                MODE_ROTATE: col[inst] = ~(4'b0001 << (k % 4));
                default:     col[inst] = 4'($urandom_range(0, 15));
            endcase
            step();
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            col[i]         = 4'hF;
            press_valid[i] = 1'b0;
            press_code[i]  = 4'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] basic press, accepted on the first edge after reset");
        applyStimulus(0, 4'h6, 4'b1101);
        runCycles(0, 46, MODE_CONST, 4'b1101);

        $display("[TB] column mismatch");
        applyStimulus(0, 4'h6, 4'b1110);
        runCycles(0, 46, MODE_CONST, 4'b1110);

        $display("[TB] column scan");
        applyStimulus(0, 4'hF, 4'b1111);
        runCycles(0, 46, MODE_ROTATE, 4'b1111);

        $display("[TB] request while busy");
        applyStimulus(0, 4'h6, 4'b1101);
        runCycles(0, 20, MODE_RAND, 4'b1111);
        press_valid[0] = 1'b1;
        press_code[0]  = 4'h3;
        runCycles(0, 3, MODE_RAND, 4'b1111);
        press_valid[0] = 1'b0;
        runCycles(0, 25, MODE_RAND, 4'b1111);
        runCycles(0, 10, MODE_CONST, 4'b0111);

        $display("[TB] reset in the middle of a press");
        applyStimulus(0, 4'h6, 4'b1101);
        runCycles(0, 20, MODE_CONST, 4'b1101);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checkOutput("rst_row", row[0], 4'b1111);
        checkOutput("rst_busy", {3'b0, busy[0]}, 4'd0);
        checkOutput("rst_press_ready", {3'b0, press_ready[0]}, 4'd1);
        checkOutput("rst_done", {3'b0, done[0]}, 4'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        applyStimulus(0, 4'h6, 4'b1101);
        runCycles(0, 46, MODE_CONST, 4'b1101);

        $display("[TB] zero-bounce press");
        applyStimulus(1, 4'h0, 4'b1110);
        runCycles(1, 22, MODE_CONST, 4'b1110);

        $display("[TB] randomized presses");
        for (int r = 0; r < 6; r++) begin
            applyStimulus(0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            runCycles(0, 46, MODE_RAND, 4'b1111);
            applyStimulus(1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            runCycles(1, 22, MODE_RAND, 4'b1111);
        end

        runCycles(0, 3, MODE_CONST, 4'b1111);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
